// File: rtl/ptmch_trg_ctrl.sv
// ptmch_trg_ctrl: Avalon-MM shadowed address windows with CS-idle-gated apply,
// plus per-channel trigger gating, one-shot arming and saturating event counters.
module ptmch_trg_ctrl #(
    parameter int P_IDLE_CYC = 4,
    parameter int P_CNT_W    = 8
) (
    input  logic        CLK160M,
    input  logic        RESET_N,
    input  logic [3:0]  AVS_ADDRESS,
    input  logic        AVS_WRITE,
    input  logic        AVS_READ,
    input  logic [31:0] AVS_WRITEDATA,
    output logic [31:0] AVS_READDATA,
    input  logic        SPI_CS,
    input  logic [4:0]  TRG_PLS_IN,
    output logic [4:0]  TRG_OUT,
    output logic [23:0] PRGEXCT_LOW_ADDR,
    output logic [23:0] PRGEXCT_HIGH_ADDR,
    output logic [23:0] RDSTAT_LOW_ADDR,
    output logic [23:0] RDSTAT_HIGH_ADDR,
    output logic [23:0] BLKERS_LOW_ADDR,
    output logic [23:0] BLKERS_HIGH_ADDR,
    output logic [23:0] PDREAD_LOW_ADDR,
    output logic [23:0] PDREAD_HIGH_ADDR,
    output logic [23:0] WRSTAT_LOW_ADDR,
    output logic [23:0] WRSTAT_HIGH_ADDR
);
    localparam int RUN_W = $clog2(P_IDLE_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_COPY} state_t;

    state_t             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               cs_meta_q, cs_sync_q;
    logic [23:0]        shd_lo_q [5];
    logic [23:0]        shd_hi_q [5];
    logic [23:0]        act_lo_q [5];
    logic [23:0]        act_hi_q [5];
    logic [4:0]         en_q, oneshot_q, armed_q, armed_d, pls_q, trg_q;
    logic [P_CNT_W-1:0] cnt_q [5];
    logic [P_CNT_W-1:0] cnt_d [5];
    logic [7:0]         cnt8 [5];
    logic [31:0]        rdata_q, rdata_d;
    logic [2:0]         idx;
    logic               wr_shd, wr_ctrl, wr_cmd, apply, rearm, clr_cnt;
    logic [4:0]         rise, fall;
    logic               unused_wdata;

    assign idx          = AVS_ADDRESS[3:1];
    assign wr_shd       = AVS_WRITE && (AVS_ADDRESS < 4'hA);
    assign wr_ctrl      = AVS_WRITE && (AVS_ADDRESS == 4'hA);
    assign wr_cmd       = AVS_WRITE && (AVS_ADDRESS == 4'hB);
    assign apply        = wr_cmd && AVS_WRITEDATA[0];
    assign rearm        = wr_cmd && AVS_WRITEDATA[1];
    assign clr_cnt      = wr_cmd && AVS_WRITEDATA[2];
    assign rise         = TRG_PLS_IN & ~pls_q;
    assign fall         = ~TRG_PLS_IN & pls_q;
    assign unused_wdata = ^AVS_WRITEDATA[31:24];

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
        end else begin
            cs_meta_q <= SPI_CS;
            cs_sync_q <= cs_meta_q;
        end
    end

    // Run length of synced CS high; only meaningful while an apply is pending.
    always_comb begin
        state_d = state_q;
        run_d   = '0;
        case (state_q)
            ST_IDLE: state_d = apply ? ST_PEND : ST_IDLE;
            ST_PEND: begin
                run_d   = cs_sync_q ? run_q + 1'b1 : '0;
                state_d = (cs_sync_q && run_q == RUN_W'(P_IDLE_CYC - 1)) ? ST_COPY : ST_PEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 5; i++) begin
                shd_lo_q[i] <= 24'h000000;
                shd_hi_q[i] <= 24'hFFFFFF;
                act_lo_q[i] <= 24'h000000;
                act_hi_q[i] <= 24'hFFFFFF;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (wr_shd && idx == 3'(i) && !AVS_ADDRESS[0]) shd_lo_q[i] <= AVS_WRITEDATA[23:0];
                if (wr_shd && idx == 3'(i) && AVS_ADDRESS[0]) shd_hi_q[i] <= AVS_WRITEDATA[23:0];
                if (state_q == ST_COPY) begin
                    act_lo_q[i] <= shd_lo_q[i];
                    act_hi_q[i] <= shd_hi_q[i];
                end
            end
        end
    end

    // One-shot clears on the falling edge so the whole first pulse is passed.
    assign armed_d = rearm ? 5'h1F : armed_q & ~(fall & oneshot_q);

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            en_q      <= 5'h1F;
            oneshot_q <= 5'h00;
            armed_q   <= 5'h1F;
            pls_q     <= 5'h00;
            trg_q     <= 5'h00;
        end else begin
            if (wr_ctrl) begin
                en_q      <= AVS_WRITEDATA[4:0];
                oneshot_q <= AVS_WRITEDATA[12:8];
            end
            armed_q <= armed_d;
            pls_q   <= TRG_PLS_IN;
            trg_q   <= TRG_PLS_IN & en_q & armed_q;
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = clr_cnt ? '0 : (rise[i] && !(&cnt_q[i])) ? cnt_q[i] + 1'b1 : cnt_q[i];
            cnt8[i]  = 8'(cnt_q[i]);
        end
    end

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (AVS_READ && AVS_ADDRESS < 4'hA) begin
            rdata_d = {8'h00, AVS_ADDRESS[0] ? shd_hi_q[idx] : shd_lo_q[idx]};
        end else if (AVS_READ) begin
            case (AVS_ADDRESS)
                4'hA:    rdata_d = {19'h0, oneshot_q, 3'h0, en_q};
                4'hC:    rdata_d = {19'h0, armed_q, 7'h0, state_q != ST_IDLE};
                4'hD:    rdata_d = {cnt8[3], cnt8[2], cnt8[1], cnt8[0]};
                4'hE:    rdata_d = {24'h0, cnt8[4]};
                default: rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) rdata_q <= 32'h0;
        else          rdata_q <= rdata_d;
    end

    assign AVS_READDATA      = rdata_q;
    assign TRG_OUT           = trg_q;
    assign PRGEXCT_LOW_ADDR  = act_lo_q[0];
    assign PRGEXCT_HIGH_ADDR = act_hi_q[0];
    assign RDSTAT_LOW_ADDR   = act_lo_q[1];
    assign RDSTAT_HIGH_ADDR  = act_hi_q[1];
    assign BLKERS_LOW_ADDR   = act_lo_q[2];
    assign BLKERS_HIGH_ADDR  = act_hi_q[2];
    assign PDREAD_LOW_ADDR   = act_lo_q[3];
    assign PDREAD_HIGH_ADDR  = act_hi_q[3];
    assign WRSTAT_LOW_ADDR   = act_lo_q[4];
    assign WRSTAT_HIGH_ADDR  = act_hi_q[4];
endmodule

// File: tb/tb_ptmch_trg_ctrl.sv
// tb_ptmch_trg_ctrl: directed stimulus feeding an expected-value queue that a
// negedge monitor drains whenever read data or a requested port sample is presented.
`timescale 1ns/1ps
module tb_ptmch_trg_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        spi_cs = 1'b1;
    logic [4:0]  trg_pls_in = '0;
    logic [4:0]  trg_out;
    logic [23:0] prg_lo, prg_hi, rds_lo, rds_hi, blk_lo, blk_hi, pdr_lo, pdr_hi, wrs_lo, wrs_hi;

    typedef struct {
        string       nm;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] act;
    logic        rd_vld = 1'b0;
    logic        smp_req = 1'b0;
    int          hi_cnt[5] = '{0, 0, 0, 0, 0};
    int          total = 0;
    int          bad = 0;

    ptmch_trg_ctrl #(.P_IDLE_CYC(4), .P_CNT_W(8)) dut (
        .CLK160M(clk), .RESET_N(rst_n),
        .AVS_ADDRESS(avs_address), .AVS_WRITE(avs_write), .AVS_READ(avs_read),
        .AVS_WRITEDATA(avs_writedata), .AVS_READDATA(avs_readdata),
        .SPI_CS(spi_cs), .TRG_PLS_IN(trg_pls_in), .TRG_OUT(trg_out),
        .PRGEXCT_LOW_ADDR(prg_lo), .PRGEXCT_HIGH_ADDR(prg_hi),
        .RDSTAT_LOW_ADDR(rds_lo), .RDSTAT_HIGH_ADDR(rds_hi),
        .BLKERS_LOW_ADDR(blk_lo), .BLKERS_HIGH_ADDR(blk_hi),
        .PDREAD_LOW_ADDR(pdr_lo), .PDREAD_HIGH_ADDR(pdr_hi),
        .WRSTAT_LOW_ADDR(wrs_lo), .WRSTAT_HIGH_ADDR(wrs_hi)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] port_val(input int s);
        case (s)
            0:  return {8'h0, prg_lo};
            1:  return {8'h0, prg_hi};
            2:  return {8'h0, wrs_lo};
            3:  return {8'h0, wrs_hi};
            4:  return {27'h0, trg_out};
            5:  return avs_readdata;
            6:  return {8'h0, rds_lo};
            10: return hi_cnt[0];
            11: return hi_cnt[1];
            12: return hi_cnt[2];
            13: return hi_cnt[3];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) rd_vld <= avs_read;

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) if (trg_out[i]) hi_cnt[i] = hi_cnt[i] + 1;
    end

    always @(negedge clk) begin
        if (rd_vld || smp_req) begin
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL scoreboard_empty: output presented with no expectation queued");
            end else begin
                e = sb.pop_front();
                act = rd_vld ? avs_readdata : port_val(e.sel);
                if (act !== e.exp) begin
                    bad = bad + 1;
                    $display("FAIL %s: got %h want %h", e.nm, act, e.exp);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        cyc(1);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
        sb.push_back('{nm, -1, exp});
        avs_address = a;
        avs_read = 1'b1;
        cyc(1);
        avs_read = 1'b0;
        cyc(1);
    endtask

    task automatic smp(input int sel, input logic [31:0] exp, input string nm);
        sb.push_back('{nm, sel, exp});
        smp_req = 1'b1;
        @(negedge clk);
        #1 smp_req = 1'b0;
        cyc(1);
    endtask

    task automatic pulse(input int ch, input int len, input int gap);
        trg_pls_in[ch] = 1'b1;
        cyc(len);
        trg_pls_in[ch] = 1'b0;
        cyc(gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        smp(0, 32'h000000, "rst_prg_lo");
        smp(1, 32'hFFFFFF, "rst_prg_hi");
        smp(4, 32'h0, "rst_trg_out");
        smp(5, 32'h0, "rst_rdata");
        rst_n = 1'b1;
        cyc(1);
        rd(4'hA, 32'h0000001F, "ctrl_rst");
        rd(4'hC, 32'h00001F00, "status_rst");
        rd(4'h9, 32'h00FFFFFF, "shd4_hi_rst");
        rd(4'hF, 32'h0, "addr_f");

        // apply held off by CS low, then copy 7 cycles after release
        spi_cs = 1'b0;
        cyc(4);
        wr(4'h0, 32'h0000_0100);
        wr(4'hB, 32'h1);
        cyc(50);
        smp(0, 32'h000000, "prg_lo_cs_low");
        rd(4'hC, 32'h00001F01, "status_pend");
        rd(4'h0, 32'h00000100, "shd0_lo");
        spi_cs = 1'b1;
        cyc(6);
        smp(0, 32'h000000, "prg_lo_before_copy");
        smp(0, 32'h000100, "prg_lo_after_copy");
        rd(4'hC, 32'h00001F00, "status_done");

        // CS glitches shorter than the idle run must not copy
        spi_cs = 1'b0;
        cyc(4);
        wr(4'h8, 32'h00AB_CDEF);
        wr(4'hB, 32'h1);
        spi_cs = 1'b1; cyc(2);
        spi_cs = 1'b0; cyc(2);
        spi_cs = 1'b1; cyc(3);
        spi_cs = 1'b0; cyc(8);
        smp(2, 32'h000000, "wrs_lo_glitch");
        rd(4'hC, 32'h00001F01, "status_glitch");
        spi_cs = 1'b1; cyc(4);
        spi_cs = 1'b0; cyc(8);
        smp(2, 32'hABCDEF, "wrs_lo_copied");
        smp(3, 32'hFFFFFF, "wrs_hi_kept");
        smp(0, 32'h000100, "prg_lo_kept");
        rd(4'hC, 32'h00001F00, "status_glitch_done");

        // one-shot on channel 1
        wr(4'hA, 32'h0000_021F);
        repeat (3) pulse(1, 16, 4);
        smp(11, 32'd16, "out1_oneshot_width");
        rd(4'hD, 32'h00000300, "cnt1_three");
        rd(4'hC, 32'h00001D00, "armed1_cleared");
        wr(4'hB, 32'h2);
        rd(4'hC, 32'h00001F00, "rearmed");
        pulse(1, 16, 4);
        smp(11, 32'd32, "out1_after_rearm");
        rd(4'hC, 32'h00001D00, "armed1_cleared_again");

        // channel 3 disabled, channel 2 enabled, one-shot off
        wr(4'hA, 32'h0000_0017);
        rd(4'hA, 32'h00000017, "ctrl_rb");
        pulse(3, 8, 4);
        pulse(2, 5, 4);
        smp(13, 32'd0, "out3_disabled");
        smp(12, 32'd5, "out2_enabled");
        rd(4'hD, 32'h01010400, "cnt3_counts");

        // saturation, armed untouched without one-shot, clear vs rising edge
        for (int i = 0; i < 300; i++) pulse(0, 1, 1);
        smp(10, 32'd300, "out0_width_sum");
        rd(4'hD, 32'h010104FF, "cnt0_sat");
        rd(4'hC, 32'h00001D00, "armed_no_oneshot");
        avs_address = 4'hB;
        avs_writedata = 32'h4;
        avs_write = 1'b1;
        trg_pls_in[0] = 1'b1;
        cyc(1);
        avs_write = 1'b0;
        cyc(3);
        trg_pls_in[0] = 1'b0;
        cyc(1);
        rd(4'hD, 32'h0, "cnt_cleared");
        rd(4'hE, 32'h0, "cnt4_cleared");
        pulse(4, 2, 2);
        rd(4'hE, 32'h1, "cnt4_one");
        wr(4'hA, 32'h0000_0A15);
        smp(5, 32'h1, "rdata_hold");

        // reset in the middle of a pending apply
        spi_cs = 1'b0;
        cyc(4);
        wr(4'h2, 32'h0012_3456);
        wr(4'hB, 32'h1);
        cyc(5);
        rst_n = 1'b0;
        smp(0, 32'h000000, "rst2_prg_lo");
        smp(2, 32'h000000, "rst2_wrs_lo");
        smp(3, 32'hFFFFFF, "rst2_wrs_hi");
        smp(5, 32'h0, "rst2_rdata");
        smp(4, 32'h0, "rst2_trg_out");
        spi_cs = 1'b1;
        rst_n = 1'b1;
        cyc(10);
        rd(4'hC, 32'h00001F00, "rst2_status");
        rd(4'hA, 32'h0000001F, "rst2_ctrl");
        rd(4'h2, 32'h0, "rst2_shd1_lo");
        rd(4'hD, 32'h0, "rst2_cnt");
        smp(6, 32'h000000, "rst2_rds_lo_no_copy");

        cyc(2);
        if (sb.size() != 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
